// File: rtl/register_file_banked.sv
// register_file_banked: banked file register array for a small 8-bit core.
// Direct addresses 0x00-0x0F are shared by all banks. Direct addresses 0x10-0x1F
// land in the bank selected by the upper FSR bits. Address 0x00 is the indirect
// port through FSR. The special registers (TMR0, PCL, STATUS, FSR, I/O ports)
// occupy the low resolved locations. Every other location is plain storage.
`timescale 1ns/1ps
module register_file_banked #(
  parameter int              DATA_W     = 8,
  parameter int              BANK_BITS  = 2,
  parameter int              PORT_COUNT = 3,
  parameter int              PC_W       = 11,
  parameter logic [PC_W-1:0] RESET_VEC  = 11'h7FF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              addr_in,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    status_en,
  input  logic [7:0]              status_in,
  input  logic                    pc_inc,
  input  logic [PC_W-9:0]         pch_in,
  input  logic [PORT_COUNT*8-1:0] port_in,
  output logic [DATA_W-1:0]       rd_data,
  output logic [PC_W-1:0]         pc_out,
  output logic [7:0]              status_out,
  output logic [7:0]              fsr_out,
  output logic [PORT_COUNT*8-1:0] port_out
);

  // Resolved location width and count: 32 locations per bank.
  localparam int AW      = 5 + BANK_BITS;
  localparam int NLOC    = 1 << AW;
  // First resolved location that is general-purpose storage.
  localparam int GP_BASE = 5 + PORT_COUNT;

  localparam logic [AW-1:0] LOC_TMR0   = AW'(1);
  localparam logic [AW-1:0] LOC_PCL    = AW'(2);
  localparam logic [AW-1:0] LOC_STATUS = AW'(3);
  localparam logic [AW-1:0] LOC_FSR    = AW'(4);

  // State registers
  logic [DATA_W-1:0] mem_q [NLOC];
  logic [7:0]        tmr_q, tmr_d;
  logic [1:0]        tmr_hold_q, tmr_hold_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        fsr_q, fsr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Decoded address and write strobes
  logic [AW-1:0] loc;
  logic          loc_is_gp;
  logic          wr_tmr;
  logic          wr_pcl;
  logic          wr_status;
  logic          wr_fsr;

  // Resolve the 5-bit instruction address into a location of the full array.
  always_comb begin
    loc = '0;
    if (addr_in == 5'd0) begin
      loc = fsr_q[AW-1:0];
    end else if (!addr_in[4]) begin
      loc = AW'(addr_in[3:0]);
    end else begin
      loc = {fsr_q[AW-1:5], addr_in};
    end
  end

  // Location 0 is only reachable indirectly. It never matches a strobe below,
  // so indirect writes to it fall away and reads of it return zero.
  assign loc_is_gp = (loc >= AW'(GP_BASE));
  assign wr_tmr    = wr_en && (loc == LOC_TMR0);
  assign wr_pcl    = wr_en && (loc == LOC_PCL);
  assign wr_status = wr_en && (loc == LOC_STATUS);
  assign wr_fsr    = wr_en && (loc == LOC_FSR);

  // General-purpose storage. It is cleared by reset, so it is built from
  // flops rather than RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NLOC; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && loc_is_gp) begin
      mem_q[loc] <= data_in;
    end
  end

  // TMR0 free-runs. A write loads it and then holds it for two cycles.
  always_comb begin
    tmr_d      = tmr_q + 8'd1;
    tmr_hold_d = tmr_hold_q;
    if (wr_tmr) begin
      tmr_d      = data_in[7:0];
      tmr_hold_d = 2'd2;
    end else if (tmr_hold_q != 2'd0) begin
      tmr_d      = tmr_q;
      tmr_hold_d = tmr_hold_q - 2'd1;
    end
  end

  // Program counter: a PCL write loads {pch_in, data} and takes priority over pc_inc.
  always_comb begin
    pc_d = pc_q;
    if (wr_pcl) begin
      pc_d = {pch_in, data_in[7:0]};
    end else if (pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // STATUS: data writes never touch TO/PD (bits 4:3). Only status_en updates those bits.
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d[7:5] = data_in[7:5];
      status_d[2:0] = data_in[2:0];
      if (status_en) begin
        status_d[4:3] = status_in[4:3];
      end
    end else if (status_en) begin
      status_d = status_in;
    end
  end

  // FSR keeps all 8 bits, including bits that no bank select uses.
  always_comb begin
    fsr_d = fsr_q;
    if (wr_fsr) begin
      fsr_d = data_in[7:0];
    end
  end

  // Read mux. It reads the value before this cycle's write. Port addresses return the pins.
  always_comb begin
    rd_data_d = '0;
    if (loc_is_gp) begin
      rd_data_d = mem_q[loc];
    end else if (loc == LOC_TMR0) begin
      rd_data_d = DATA_W'(tmr_q);
    end else if (loc == LOC_PCL) begin
      rd_data_d = DATA_W'(pc_q[7:0]);
    end else if (loc == LOC_STATUS) begin
      rd_data_d = DATA_W'(status_q);
    end else if (loc == LOC_FSR) begin
      rd_data_d = DATA_W'(fsr_q);
    end else begin
      for (int k = 0; k < PORT_COUNT; k++) begin
        if (loc == AW'(5 + k)) begin
          rd_data_d = DATA_W'(port_in[8*k +: 8]);
        end
      end
    end
  end

  // Special-register and read-data state update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q      <= 8'h00;
      tmr_hold_q <= 2'd0;
      pc_q       <= RESET_VEC;
      status_q   <= 8'h18;
      fsr_q      <= 8'h00;
      rd_data_q  <= '0;
    end else begin
      tmr_q      <= tmr_d;
      tmr_hold_q <= tmr_hold_d;
      pc_q       <= pc_d;
      status_q   <= status_d;
      fsr_q      <= fsr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // One output latch per I/O port. The latch drives port_out, not the read path.
  for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_port
    logic [7:0] latch_q, latch_d;
    logic       wr_port;

    assign wr_port = wr_en && (loc == AW'(5 + gi));

    // Load the latch when this port's location is written.
    always_comb begin
      latch_d = latch_q;
      if (wr_port) begin
        latch_d = data_in[7:0];
      end
    end

    // Port latch register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        latch_q <= 8'h00;
      end else begin
        latch_q <= latch_d;
      end
    end

    assign port_out[8*gi +: 8] = latch_q;
  end

  assign rd_data    = rd_data_q;
  assign pc_out     = pc_q;
  assign status_out = status_q;
  assign fsr_out    = fsr_q;

endmodule

// File: tb/tb_register_file_banked.sv
// Testbench for register_file_banked at default parameters. Directed scenarios
// and a randomized run are checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_register_file_banked;

  logic        clk;
  logic        rst;
  logic [4:0]  addr_in;
  logic        wr_en;
  logic [7:0]  data_in;
  logic        status_en;
  logic [7:0]  status_in;
  logic        pc_inc;
  logic [2:0]  pch_in;
  logic [23:0] port_in;
  logic [7:0]  rd_data;
  logic [10:0] pc_out;
  logic [7:0]  status_out;
  logic [7:0]  fsr_out;
  logic [23:0] port_out;

  int vectors;
  int miscompares;
  int txn;

  // Reference model state.
  logic [7:0] m_mem [128];
  logic [7:0] m_fsr;
  logic [7:0] m_status;
  logic [7:0] m_ports [3];
  int         m_pc;
  int         edge_n;
  int         tmr_base_edge;
  int         tmr_base_delay;
  logic [7:0] tmr_base_val;
  logic [7:0] exp_rd;

  register_file_banked #(
    .DATA_W(8), .BANK_BITS(2), .PORT_COUNT(3), .PC_W(11), .RESET_VEC(11'h7FF)
  ) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wr_en(wr_en), .data_in(data_in),
    .status_en(status_en), .status_in(status_in), .pc_inc(pc_inc), .pch_in(pch_in),
    .port_in(port_in), .rd_data(rd_data), .pc_out(pc_out), .status_out(status_out),
    .fsr_out(fsr_out), .port_out(port_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model of TMR0: it counts from its last load, after that load's hold time.
  function automatic logic [7:0] m_tmr();
    int run;
    run = edge_n - tmr_base_edge - tmr_base_delay;
    if (run < 0) run = 0;
    return tmr_base_val + 8'(run);
  endfunction

  function automatic int resolve(input logic [4:0] a, input logic [7:0] f);
    if (a == 5'd0) return int'(f) % 128;
    if (a < 5'd16) return int'(a);
    return ((int'(f) / 32) % 4) * 32 + int'(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) m_ports[i] = 8'h00;
    m_fsr = 8'h00;
    m_status = 8'h18;
    m_pc = 11'h7FF;
    edge_n = 0;
    tmr_base_edge = 0;
    tmr_base_delay = 0;
    tmr_base_val = 8'h00;
  endtask

  // Advance the model one clock using the inputs currently driven.
  task automatic model_step();
    int loc;
    loc = resolve(addr_in, m_fsr);
    if (loc == 0) exp_rd = 8'h00;
    else if (loc == 1) exp_rd = m_tmr();
    else if (loc == 2) exp_rd = 8'(m_pc % 256);
    else if (loc == 3) exp_rd = m_status;
    else if (loc == 4) exp_rd = m_fsr;
    else if (loc < 8) exp_rd = port_in[8*(loc-5) +: 8];
    else exp_rd = m_mem[loc];
    edge_n++;
    if (wr_en && loc == 2) m_pc = int'(pch_in) * 256 + int'(data_in);
    else if (pc_inc) m_pc = (m_pc + 1) % 2048;
    if (wr_en && loc == 3) m_status = (data_in & 8'hE7) | ((status_en ? status_in : m_status) & 8'h18);
    else if (status_en) m_status = status_in;
    if (wr_en && loc == 1) begin
      tmr_base_edge = edge_n;
      tmr_base_val = data_in;
      tmr_base_delay = 2;
    end
    if (wr_en && loc == 4) m_fsr = data_in;
    if (wr_en && loc >= 5 && loc < 8) m_ports[loc-5] = data_in;
    if (wr_en && loc >= 8) m_mem[loc] = data_in;
  endtask

  // Drive one cycle of inputs, update the model, and sample 1 ns after the edge.
  task automatic step(input logic [4:0] a, input logic w, input logic [7:0] d,
                      input logic se, input logic [7:0] si, input logic inc,
                      input logic [2:0] ph);
    addr_in = a; wr_en = w; data_in = d; status_en = se; status_in = si;
    pc_inc = inc; pch_in = ph;
    model_step();
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d addr=%h wr=%0d data=%h sen=%0d inc=%0d -> rd=%h pc=%h st=%h fsr=%h",
             txn, a, w, d, se, inc, rd_data, pc_out, status_out, fsr_out);
  endtask

  task automatic rd_step(input logic [4:0] a);
    step(a, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic wr_step(input logic [4:0] a, input logic [7:0] d);
    step(a, 1'b1, d, 1'b0, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr_in = 5'd0; wr_en = 1'b0; data_in = 8'h00; status_en = 1'b0;
    status_in = 8'h00; pc_inc = 1'b0; pch_in = 3'd0; port_in = 24'h000000;
    #1 rst = 1'b0;
    #2;
    vectors++; if (pc_out !== 11'h7FF) begin miscompares++; $display("FAIL reset_pc: got %h want 7ff", pc_out); end
    vectors++; if (status_out !== 8'h18) begin miscompares++; $display("FAIL reset_status: got %h want 18", status_out); end
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (fsr_out !== 8'h00) begin miscompares++; $display("FAIL reset_fsr: got %h want 00", fsr_out); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd: got %h want 00", rd_data); end
    vectors++; if (port_out !== 24'h0) begin miscompares++; $display("FAIL reset_port_out: got %h want 000000", port_out); end
    #2 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_banking();
    wr_step(5'h04, 8'h45);
    wr_step(5'h12, 8'hA5);
    wr_step(5'h04, 8'h52);
    vectors++; if (fsr_out !== 8'h52) begin miscompares++; $display("FAIL bank_fsr: got %h want 52", fsr_out); end
    rd_step(5'h00);
    vectors++; if (rd_data !== 8'hA5) begin miscompares++; $display("FAIL bank_indirect_read: got %h want a5", rd_data); end
    wr_step(5'h04, 8'h00);
    rd_step(5'h12);
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL bank0_read: got %h want 00", rd_data); end
    // Indirect access to location 0 reads zero and discards the write.
    wr_step(5'h00, 8'h77);
    rd_step(5'h00);
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL indf_zero: got %h want 00", rd_data); end
    // FSR bit 7 is stored even though no bank select uses it.
    wr_step(5'h04, 8'hE3);
    rd_step(5'h04);
    vectors++; if (rd_data !== 8'hE3) begin miscompares++; $display("FAIL fsr_bit7: got %h want e3", rd_data); end
    wr_step(5'h04, 8'h00);
  endtask

  task automatic test_pc();
    step(5'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0);
    vectors++; if (pc_out !== 11'h000) begin miscompares++; $display("FAIL pc_wrap: got %h want 000", pc_out); end
    step(5'h02, 1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 3'd5);
    vectors++; if (pc_out !== 11'h534) begin miscompares++; $display("FAIL pcl_write: got %h want 534", pc_out); end
    step(5'h0A, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 3'd0);
    vectors++; if (pc_out !== 11'h535) begin miscompares++; $display("FAIL pc_inc_with_write: got %h want 535", pc_out); end
    rd_step(5'h0A);
    vectors++; if (rd_data !== 8'h11) begin miscompares++; $display("FAIL concurrent_write: got %h want 11", rd_data); end
    rd_step(5'h02);
    vectors++; if (rd_data !== 8'h35) begin miscompares++; $display("FAIL pcl_read: got %h want 35", rd_data); end
  endtask

  task automatic test_tmr0();
    logic [7:0] want [5];
    want[0] = 8'hFE; want[1] = 8'hFE; want[2] = 8'hFE; want[3] = 8'hFF; want[4] = 8'h00;
    wr_step(5'h01, 8'hFE);
    for (int i = 0; i < 5; i++) begin
      rd_step(5'h01);
      vectors++;
      if (rd_data !== want[i]) begin
        miscompares++;
        $display("FAIL tmr0_seq[%0d]: got %h want %h", i, rd_data, want[i]);
      end
    end
  endtask

  task automatic test_status();
    wr_step(5'h03, 8'hFF);
    vectors++; if (status_out !== 8'hFF) begin miscompares++; $display("FAIL status_write_keeps_to_pd: got %h want ff", status_out); end
    step(5'h00, 1'b0, 8'h00, 1'b1, 8'h18, 1'b0, 3'd0);
    step(5'h03, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0);
    vectors++; if (status_out !== 8'hE7) begin miscompares++; $display("FAIL status_write_and_en: got %h want e7", status_out); end
    step(5'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 3'd0);
    vectors++; if (status_out !== 8'h5A) begin miscompares++; $display("FAIL status_en_alone: got %h want 5a", status_out); end
    wr_step(5'h03, 8'h00);
    vectors++; if (status_out !== 8'h18) begin miscompares++; $display("FAIL status_clear_writable: got %h want 18", status_out); end
  endtask

  task automatic test_ports();
    port_in = 24'hC3_5A_3C;
    wr_step(5'h05, 8'h81);
    vectors++; if (port_out[7:0] !== 8'h81) begin miscompares++; $display("FAIL port0_latch: got %h want 81", port_out[7:0]); end
    rd_step(5'h05);
    vectors++; if (rd_data !== 8'h3C) begin miscompares++; $display("FAIL port0_pins: got %h want 3c", rd_data); end
    wr_step(5'h07, 8'h42);
    vectors++; if (port_out !== 24'h42_00_81) begin miscompares++; $display("FAIL port2_latch: got %h want 420081", port_out); end
    rd_step(5'h07);
    vectors++; if (rd_data !== 8'hC3) begin miscompares++; $display("FAIL port2_pins: got %h want c3", rd_data); end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 5'h04;
      port_in = 24'($urandom);
      step(a, 1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
           8'($urandom), 1'($urandom), 3'($urandom));
      vectors++; if (rd_data !== exp_rd) begin miscompares++; $display("FAIL rand_rd[%0d]: got %h want %h", n, rd_data, exp_rd); end
      vectors++; if (pc_out !== 11'(m_pc)) begin miscompares++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc_out, 11'(m_pc)); end
      vectors++; if (status_out !== m_status) begin miscompares++; $display("FAIL rand_status[%0d]: got %h want %h", n, status_out, m_status); end
      vectors++; if (fsr_out !== m_fsr) begin miscompares++; $display("FAIL rand_fsr[%0d]: got %h want %h", n, fsr_out, m_fsr); end
      vectors++; if (port_out !== {m_ports[2], m_ports[1], m_ports[0]}) begin
        miscompares++;
        $display("FAIL rand_port_out[%0d]: got %h want %h", n, port_out, {m_ports[2], m_ports[1], m_ports[0]});
      end
    end
    port_in = 24'h0;
  endtask

  task automatic test_reset_midwrite();
    wr_step(5'h04, 8'h00);
    addr_in = 5'h1C; wr_en = 1'b1; data_in = 8'h99; pc_inc = 1'b1;
    #2 rst = 1'b0;
    #1;
    vectors++; if (pc_out !== 11'h7FF) begin miscompares++; $display("FAIL async_reset_pc: got %h want 7ff", pc_out); end
    vectors++; if (status_out !== 8'h18) begin miscompares++; $display("FAIL async_reset_status: got %h want 18", status_out); end
    vectors++; if (fsr_out !== 8'h00) begin miscompares++; $display("FAIL async_reset_fsr: got %h want 00", fsr_out); end
    @(posedge clk); #1;
    vectors++; if (pc_out !== 11'h7FF) begin miscompares++; $display("FAIL held_reset_pc: got %h want 7ff", pc_out); end
    #2;
    wr_en = 1'b0; pc_inc = 1'b0;
    rst = 1'b1;
    model_reset();
    rd_step(5'h1C);
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_discards_write: got %h want 00", rd_data); end
    rd_step(5'h01);
    vectors++; if (rd_data !== 8'h01) begin miscompares++; $display("FAIL tmr0_after_reset: got %h want 01", rd_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    txn = 0;
    model_reset();
    test_reset();
    test_banking();
    test_pc();
    test_tmr0();
    test_status();
    test_ports();
    test_random();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
